// File: rtl/effect_chain_scheduler.sv
// Effect chain scheduler: walks one audio sample through the enabled effect
// stages in ascending index order over a shared issue bus. A stage that does
// not answer within TIMEOUT cycles is skipped with its sample left unchanged,
// and a sticky flag records the timeout.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | ready for a sample; mask==0 samples pass straight through
// S_ISSUE | o_fx_valid high for the selected stage, wait counter cleared
// S_WAIT  | watching only the selected stage's response line, counting
module effect_chain_scheduler #(
    parameter int NUM_FX  = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    input  logic [DW-1:0]        i_data,
    output logic                 o_ready,
    input  logic [NUM_FX-1:0]    i_fx_mask,
    output logic                 o_fx_valid,
    output logic [NUM_FX-1:0]    o_fx_sel,
    output logic [DW-1:0]        o_fx_data,
    input  logic [NUM_FX-1:0]    i_fx_valid,
    input  logic [NUM_FX*DW-1:0] i_fx_data,
    output logic                 o_valid,
    output logic [DW-1:0]        o_data,
    input  logic                 i_clr,
    output logic [NUM_FX-1:0]    o_timeout,
    output logic                 o_overrun
);

    localparam int IW = (NUM_FX > 1) ? $clog2(NUM_FX) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [NUM_FX-1:0]   rem_q, rem_d;      // stages of the snapshot still to visit
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [DW-1:0]       work_q, work_d;
    logic                ready_q, ready_d;
    logic                fx_valid_q, fx_valid_d;
    logic [NUM_FX-1:0]   fx_sel_q, fx_sel_d;
    logic [DW-1:0]       fx_data_q, fx_data_d;
    logic                valid_q, valid_d;
    logic [DW-1:0]       data_q, data_d;
    logic [NUM_FX-1:0]   timeout_q, timeout_d;
    logic                overrun_q, overrun_d;

    logic                resp_hit;
    logic [DW-1:0]       resp_data;
    logic [DW-1:0]       next_work;
    logic [IW-1:0]       next_idx;

    function automatic logic [IW-1:0] lowest_set(input logic [NUM_FX-1:0] m);
        lowest_set = '0;
        for (int k = NUM_FX - 1; k >= 0; k--) begin
            if (m[k]) lowest_set = IW'(k);
        end
    endfunction

    function automatic logic [NUM_FX-1:0] onehot(input logic [IW-1:0] i);
        onehot = '0;
        for (int k = 0; k < NUM_FX; k++) begin
            onehot[k] = (IW'(k) == i);
        end
    endfunction

    assign resp_hit  = i_fx_valid[idx_q];
    assign resp_data = i_fx_data[int'(idx_q)*DW +: DW];

    // Next-state and registered-output decode for the sequencing FSM.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rem_d      = rem_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        fx_valid_d = 1'b0;
        fx_sel_d   = fx_sel_q;
        fx_data_d  = fx_data_q;
        valid_d    = 1'b0;
        data_d     = data_q;
        timeout_d  = timeout_q;
        overrun_d  = overrun_q;
        next_work  = work_q;
        next_idx   = lowest_set(rem_q);

        // Clear first so that a flag raised on the same edge survives.
        if (i_clr) begin
            timeout_d = '0;
            overrun_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    work_d = i_data;
                    if (i_fx_mask == '0) begin
                        valid_d = 1'b1;
                        data_d  = i_data;
                    end else begin
                        idx_d      = lowest_set(i_fx_mask);
                        rem_d      = i_fx_mask & ~onehot(idx_d);
                        state_d    = S_ISSUE;
                        fx_valid_d = 1'b1;
                        fx_sel_d   = onehot(idx_d);
                        fx_data_d  = i_data;
                    end
                end
            end
            S_ISSUE: begin
                if (i_valid) overrun_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (i_valid) overrun_d = 1'b1;
                if (resp_hit || cnt_q == CW'(TIMEOUT - 1)) begin
                    if (resp_hit) next_work = resp_data;
                    else          timeout_d[idx_q] = 1'b1;
                    work_d = next_work;
                    if (rem_q != '0) begin
                        idx_d      = next_idx;
                        rem_d      = rem_q & ~onehot(next_idx);
                        state_d    = S_ISSUE;
                        fx_valid_d = 1'b1;
                        fx_sel_d   = onehot(next_idx);
                        fx_data_d  = next_work;
                    end else begin
                        state_d  = S_IDLE;
                        valid_d  = 1'b1;
                        data_d   = next_work;
                        fx_sel_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                fx_sel_d = '0;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State, datapath and output registers; reset drops any in-flight sample.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            work_q     <= '0;
            ready_q    <= 1'b1;
            fx_valid_q <= 1'b0;
            fx_sel_q   <= '0;
            fx_data_q  <= '0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            timeout_q  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rem_q      <= rem_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            ready_q    <= ready_d;
            fx_valid_q <= fx_valid_d;
            fx_sel_q   <= fx_sel_d;
            fx_data_q  <= fx_data_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            timeout_q  <= timeout_d;
            overrun_q  <= overrun_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_fx_valid = fx_valid_q;
    assign o_fx_sel   = fx_sel_q;
    assign o_fx_data  = fx_data_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_timeout  = timeout_q;
    assign o_overrun  = overrun_q;

endmodule

// File: tb/tb_effect_chain_scheduler.sv
// Bench for effect_chain_scheduler: table of chain vectors plus hand-written
// sequences (back-to-back, overrun, clear priority, stray response, reset).
module tb_effect_chain_scheduler;

    localparam int NUM_FX  = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 20;

    logic                 clk = 1'b0;
    logic                 i_rst_n;
    logic                 i_valid;
    logic [DW-1:0]        i_data;
    logic                 o_ready;
    logic [NUM_FX-1:0]    i_fx_mask;
    logic                 o_fx_valid;
    logic [NUM_FX-1:0]    o_fx_sel;
    logic [DW-1:0]        o_fx_data;
    logic [NUM_FX-1:0]    i_fx_valid;
    logic [NUM_FX*DW-1:0] i_fx_data;
    logic                 o_valid;
    logic [DW-1:0]        o_data;
    logic                 i_clr;
    logic [NUM_FX-1:0]    o_timeout;
    logic                 o_overrun;

    always #5 clk = ~clk;

    effect_chain_scheduler #(.NUM_FX(NUM_FX), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_ready    (o_ready),
        .i_fx_mask  (i_fx_mask),
        .o_fx_valid (o_fx_valid),
        .o_fx_sel   (o_fx_sel),
        .o_fx_data  (o_fx_data),
        .i_fx_valid (i_fx_valid),
        .i_fx_data  (i_fx_data),
        .o_valid    (o_valid),
        .o_data     (o_data),
        .i_clr      (i_clr),
        .o_timeout  (o_timeout),
        .o_overrun  (o_overrun)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int                lat [NUM_FX];      // response latency per stage, 0 = never answers
    bit                stray_en = 1'b0;   // stage 3 strobes while stage 1 is selected
    logic [NUM_FX-1:0] sel_log [$];

    typedef struct {
        logic [DW-1:0] data;
        int            lat;
        int            t0;
    } exp_t;
    exp_t sb [$];

    typedef struct {
        logic [3:0]    mask;
        logic [DW-1:0] data;
        int            l0, l1, l2, l3;
        logic [DW-1:0] exp_data;
        int            exp_lat;
    } vec_t;
    vec_t vt [7];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] stage_op(input int k, input logic [DW-1:0] x);
        case (k)
            0:       return x + 16'd100;
            1:       return x - 16'd7;
            2:       return x << 1;
            default: return x ^ 16'h00FF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stage models: answer L cycles after the issue pulse with the stage's function.
    initial begin : responder
        int            cd [NUM_FX];
        logic [DW-1:0] hx [NUM_FX];
        for (int k = 0; k < NUM_FX; k++) begin
            cd[k] = 0;
            hx[k] = '0;
        end
        i_fx_valid = '0;
        i_fx_data  = '0;
        forever begin
            @(negedge clk);
            i_fx_valid = '0;
            if (!i_rst_n) begin
                for (int k = 0; k < NUM_FX; k++) cd[k] = 0;
            end
            for (int k = 0; k < NUM_FX; k++) begin
                if (cd[k] > 0) begin
                    cd[k]--;
                    if (cd[k] == 0) begin
                        i_fx_valid[k]          = 1'b1;
                        i_fx_data[k*DW +: DW] = stage_op(k, hx[k]);
                    end
                end
            end
            if (o_fx_valid && i_rst_n) begin
                sel_log.push_back(o_fx_sel);
                for (int k = 0; k < NUM_FX; k++) begin
                    if (o_fx_sel[k]) begin
                        if (lat[k] > 0) begin
                            cd[k] = lat[k];
                            hx[k] = o_fx_data;
                        end
                        if (stray_en && k == 1) begin
                            cd[3] = 1;
                            hx[3] = 16'h7777;
                        end
                    end
                end
            end
        end
    end

    // Output monitor: every o_valid must match the oldest expected sample.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_o_valid: got o_data=0x%0h with nothing expected (cycle %0d)", o_data, cyc);
                end else begin
                    e = sb.pop_front();
                    check("o_data", 32'(o_data), 32'(e.data));
                    check("latency", 32'(cyc - e.t0), 32'(e.lat));
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_lat(input int l0, input int l1, input int l2, input int l3);
        lat[0] = l0; lat[1] = l1; lat[2] = l2; lat[3] = l3;
    endtask

    // Drive one sample for a cycle; mask is then scrambled to prove the snapshot.
    task automatic send(input logic [3:0] m, input logic [DW-1:0] d, input bit accepted,
                        input logic [DW-1:0] ed, input int el);
        exp_t e;
        i_valid   = 1'b1;
        i_data    = d;
        i_fx_mask = m;
        if (accepted) begin
            e.data = ed;
            e.lat  = el;
            e.t0   = cyc;
            sb.push_back(e);
        end
        @(negedge clk);
        i_valid   = 1'b0;
        i_fx_mask = ~m;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_output: got no o_valid within 300 cycles, required %0d pending", sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic pulse_clr();
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        // mask, data, L0..L3, expected data, expected latency
        vt[0] = '{4'b0000, 16'hFB2E, 0, 0, 0, 0, 16'hFB2E, 1};   // -1234 passes through
        vt[1] = '{4'b0101, 16'd10,   1, 0, 3, 0, 16'd220,  7};   // (10+100)*2
        vt[2] = '{4'b0010, 16'd500,  0, 0, 0, 0, 16'd500,  22};  // stage 1 times out
        vt[3] = '{4'b1111, 16'd0,    1, 1, 1, 1, 16'd69,   9};   // ((0+100-7)*2)^0xFF
        vt[4] = '{4'b1000, 16'hFFFF, 0, 0, 0, 2, 16'hFF00, 4};   // -1 ^ 0x00FF
        vt[5] = '{4'b0110, 16'h7FFF, 0, 4, 1, 0, 16'hFFF0, 8};   // (32767-7)*2 wraps
        vt[6] = '{4'b1001, 16'hFF9C, 2, 0, 0, 0, 16'd0,    25};  // -100+100, stage 3 times out

        set_lat(0, 0, 0, 0);
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_data    = '0;
        i_fx_mask = '0;
        i_clr     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready",    32'(o_ready),    32'd1);
        check("rst_valid",    32'(o_valid),    32'd0);
        check("rst_fx_valid", 32'(o_fx_valid), 32'd0);
        check("rst_fx_sel",   32'(o_fx_sel),   32'd0);
        check("rst_data",     32'(o_data),     32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            set_lat(vt[i].l0, vt[i].l1, vt[i].l2, vt[i].l3);
            sel_log.delete();
            send(vt[i].mask, vt[i].data, 1'b1, vt[i].exp_data, vt[i].exp_lat);
            wait_idle();
            check($sformatf("issue_count[%0d]", i), 32'(sel_log.size()), 32'($countones(vt[i].mask)));
            if (i == 1 && sel_log.size() >= 2) begin
                check("sel_first",  32'(sel_log[0]), 32'b0001);
                check("sel_second", 32'(sel_log[1]), 32'b0100);
            end
        end
        check("timeout_flags", 32'(o_timeout), 32'b1010);
        check("no_overrun",    32'(o_overrun), 32'd0);
        pulse_clr();
        check("timeout_clr",   32'(o_timeout), 32'd0);

        // Sample arriving in the same cycle as o_valid is accepted.
        set_lat(0, 0, 0, 0);
        send(4'b0000, 16'd5, 1'b1, 16'd5, 1);
        send(4'b0000, 16'd6, 1'b1, 16'd6, 1);
        wait_idle();
        check("b2b_no_overrun", 32'(o_overrun), 32'd0);

        // Second sample two cycles into a busy chain is dropped.
        set_lat(5, 0, 0, 0);
        send(4'b0001, 16'd7, 1'b1, 16'd107, 7);
        @(negedge clk);
        check("busy_ready", 32'(o_ready), 32'd0);
        send(4'b0001, 16'd8, 1'b0, 16'd0, 0);
        wait_idle();
        repeat (10) @(negedge clk);
        check("overrun_set", 32'(o_overrun), 32'd1);
        pulse_clr();
        check("overrun_clr", 32'(o_overrun), 32'd0);

        // Clear and a fresh overrun on the same edge: the flag stays set.
        send(4'b0001, 16'd1, 1'b1, 16'd101, 7);
        @(negedge clk);
        i_valid = 1'b1;
        i_clr   = 1'b1;
        @(negedge clk);
        i_valid = 1'b0;
        i_clr   = 1'b0;
        check("set_wins", 32'(o_overrun), 32'd1);
        wait_idle();
        pulse_clr();

        // Stage 3 strobes while stage 1 is selected; only stage 1 counts.
        set_lat(0, 3, 0, 0);
        stray_en = 1'b1;
        send(4'b0010, 16'd40, 1'b1, 16'd33, 5);
        wait_idle();
        stray_en = 1'b0;

        // Reset while waiting on a silent stage discards the sample.
        set_lat(0, 0, 0, 0);
        send(4'b0010, 16'd9, 1'b0, 16'd0, 0);
        repeat (3) @(negedge clk);
        check("wait_busy", 32'(o_ready), 32'd0);
        i_rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ready",   32'(o_ready),    32'd1);
        check("mid_rst_valid",   32'(o_valid),    32'd0);
        check("mid_rst_fxvalid", 32'(o_fx_valid), 32'd0);
        check("mid_rst_fxsel",   32'(o_fx_sel),   32'd0);
        check("mid_rst_fxdata",  32'(o_fx_data),  32'd0);
        check("mid_rst_data",    32'(o_data),     32'd0);
        check("mid_rst_timeout", 32'(o_timeout),  32'd0);
        check("mid_rst_overrun", 32'(o_overrun),  32'd0);
        i_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        set_lat(1, 0, 0, 0);
        send(4'b0001, 16'd3, 1'b1, 16'd103, 3);
        wait_idle();
        repeat (TIMEOUT + 5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
